memory_access: RTL and testbench

MEM stage of the five-stage pipeline, directly upstream of write-back: performs loads and stores against a word-organised data memory and latches the MEM/WB pipeline register that supplies write-back's memory data, ALU data, destination register and MemtoReg select. It supports byte, halfword and word accesses with big-endian lane selection and load sign/zero extension. It also supports pipeline stall and flush.

---
 rtl/memory_access.sv | 150 +++++++++++++++
 tb/tb_memory_access.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// MEM pipeline stage: byte/half/word loads and stores on a word-organised data memory, feeding the MEM/WB register.
// Latency: 1 cycle (inputs sampled at edge N appear on outputs after edge N); stores commit on that same edge.
// Backpressure: stall freezes MEM/WB and suppresses the store; flush bubbles MEM/WB and beats stall; no handshake.
//
// Ports: clk, reset (sync, active-low); stall/flush pipeline control; ALU_result (byte address / passthrough),
//        write_data (store data), wb_reg_in, MemRead, MemWrite, MemSize, MemSigned, RegWrite_in, MemtoReg_in;
//        registered outputs mem_data, ALU_data, wb_reg, RegWrite, MemtoReg, misalign.
// Optional feature: define MEM_ALIGN_CHECK_EN to fault misaligned half/word accesses; otherwise misalign stays 0.
module memory_access #(
    parameter int B = 32,
    parameter int D = 5,
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         flush,
    input  logic [B-1:0] ALU_result,
    input  logic [B-1:0] write_data,
    input  logic [D-1:0] wb_reg_in,
    input  logic         MemRead,
    input  logic         MemWrite,
    input  logic [1:0]   MemSize,
    input  logic         MemSigned,
    input  logic         RegWrite_in,
    input  logic         MemtoReg_in,
    output logic [B-1:0] mem_data,
    output logic [B-1:0] ALU_data,
    output logic [D-1:0] wb_reg,
    output logic         RegWrite,
    output logic         MemtoReg,
    output logic         misalign
);

    logic [31:0]  mem_q [0:(1<<W)-1];

    logic [W-1:0] word_idx;
    logic [1:0]   byte_off;
    logic [31:0]  rd_word;
    logic         fault;

    assign word_idx = ALU_result[W+1:2];
    assign byte_off = ALU_result[1:0];
    assign rd_word  = mem_q[word_idx];

`ifdef MEM_ALIGN_CHECK_EN
    // Only real memory operations can fault; byte accesses are always aligned.
    always_comb begin
        fault = 1'b0;
        if (MemRead || MemWrite) begin
            if (MemSize == 2'b01)
                fault = byte_off[0];
            else if (MemSize[1])
                fault = (byte_off != 2'b00);
        end
    end
`else
    assign fault = 1'b0;
`endif

    // Load extraction, big-endian lanes: offset 0 is the most significant byte.
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_ext;

    always_comb begin
        byte_v   = 8'h00;
        half_v   = 16'h0000;
        load_ext = rd_word;
        case (byte_off)
            2'd0:    byte_v = rd_word[31:24];
            2'd1:    byte_v = rd_word[23:16];
            2'd2:    byte_v = rd_word[15:8];
            default: byte_v = rd_word[7:0];
        endcase
        half_v = byte_off[1] ? rd_word[15:0] : rd_word[31:16];
        case (MemSize)
            2'b00:   load_ext = MemSigned ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
            2'b01:   load_ext = MemSigned ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
            default: load_ext = rd_word;
        endcase
    end

    // Store lane replication plus byte enables (bit 3 = bits [31:24]).
    logic [31:0] st_dat;
    logic [3:0]  st_be;
    logic        st_en;

    always_comb begin
        st_dat = write_data;
        st_be  = 4'b1111;
        case (MemSize)
            2'b00: begin
                st_dat = {4{write_data[7:0]}};
                st_be  = 4'b1000 >> byte_off;
            end
            2'b01: begin
                st_dat = {2{write_data[15:0]}};
                st_be  = byte_off[1] ? 4'b0011 : 4'b1100;
            end
            default: begin
                st_dat = write_data;
                st_be  = 4'b1111;
            end
        endcase
    end

    assign st_en = MemWrite && !stall && !flush && reset && !fault;

    // Memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (st_en) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i])
                    mem_q[word_idx][8*i +: 8] <= st_dat[8*i +: 8];
            end
        end
    end

    // MEM/WB register: reset > flush > stall > normal.
    logic [B-1:0] mem_data_q, ALU_data_q;
    logic [D-1:0] wb_reg_q;
    logic         RegWrite_q, MemtoReg_q, misalign_q;

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            mem_data_q <= '0;
            ALU_data_q <= '0;
            wb_reg_q   <= '0;
            RegWrite_q <= 1'b0;
            MemtoReg_q <= 1'b0;
            misalign_q <= 1'b0;
        end else if (!stall) begin
            mem_data_q <= load_ext;
            ALU_data_q <= ALU_result;
            wb_reg_q   <= wb_reg_in;
            RegWrite_q <= RegWrite_in && !fault;
            MemtoReg_q <= MemtoReg_in;
            misalign_q <= fault;
        end
    end

    assign mem_data = mem_data_q;
    assign ALU_data = ALU_data_q;
    assign wb_reg   = wb_reg_q;
    assign RegWrite = RegWrite_q;
    assign MemtoReg = MemtoReg_q;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: hand-computed expectations checked with immediate assertions.
// Latency: outputs checked 1ns after each rising edge, one edge after inputs are applied.
// Backpressure: exercises stall, flush, flush-over-stall and mid-stream reset.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic [31:0] ALU_result, write_data;
    logic [4:0]  wb_reg_in;
    logic        MemRead, MemWrite, MemSigned, RegWrite_in, MemtoReg_in;
    logic [1:0]  MemSize;
    logic [31:0] mem_data, ALU_data;
    logic [4:0]  wb_reg;
    logic        RegWrite, MemtoReg, misalign;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    memory_access #(.B(32), .D(5), .W(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .ALU_result (ALU_result),
        .write_data (write_data),
        .wb_reg_in  (wb_reg_in),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemSize    (MemSize),
        .MemSigned  (MemSigned),
        .RegWrite_in(RegWrite_in),
        .MemtoReg_in(MemtoReg_in),
        .mem_data   (mem_data),
        .ALU_data   (ALU_data),
        .wb_reg     (wb_reg),
        .RegWrite   (RegWrite),
        .MemtoReg   (MemtoReg),
        .misalign   (misalign)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                      input logic rde, input logic wre, input logic [1:0] sz, input logic sgn,
                      input logic rw, input logic m2r);
        ALU_result  = addr;
        write_data  = wd;
        wb_reg_in   = rd;
        MemRead     = rde;
        MemWrite    = wre;
        MemSize     = sz;
        MemSigned   = sgn;
        RegWrite_in = rw;
        MemtoReg_in = m2r;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_data"}, mem_data, 32'h0);
        chk({tag, "_ALU_data"}, ALU_data, 32'h0);
        chk({tag, "_wb_reg"},   {27'h0, wb_reg}, 32'h0);
        chk({tag, "_RegWrite"}, {31'h0, RegWrite}, 32'h0);
        chk({tag, "_MemtoReg"}, {31'h0, MemtoReg}, 32'h0);
        chk({tag, "_misalign"}, {31'h0, misalign}, 32'h0);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        chk_all_zero("reset");

        reset = 1'b1;
        // Word store then word load.
        op(32'h10, 32'hDEADBEEF, 5'd3, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        tick();
        chk("st_alu", ALU_data, 32'h10);
        chk("st_rw", {31'h0, RegWrite}, 32'h0);
        op(32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1);
        tick();
        chk("ldw", mem_data, 32'hDEADBEEF);
        chk("ldw_m2r", {31'h0, MemtoReg}, 32'h1);
        chk("ldw_wb", {27'h0, wb_reg}, 32'd5);
        chk("ldw_rw", {31'h0, RegWrite}, 32'h1);

        // Sub-word loads with extension.
        op(32'h11, 32'h0, 5'd5, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1); tick();
        chk("ldb_s11", mem_data, 32'hFFFFFFAD);
        op(32'h11, 32'h0, 5'd5, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1); tick();
        chk("ldb_u11", mem_data, 32'h000000AD);
        op(32'h12, 32'h0, 5'd5, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1); tick();
        chk("ldh_s12", mem_data, 32'hFFFFBEEF);
        op(32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1); tick();
        chk("ldh_u10", mem_data, 32'h0000DEAD);
        op(32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1); tick();
        chk("ldb_s10", mem_data, 32'hFFFFFFDE);

        // Byte store with simultaneous load: load sees pre-store contents.
        op(32'h13, 32'h12345655, 5'd0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0); tick();
        chk("stld_pre", mem_data, 32'h000000EF);
        op(32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1); tick();
        chk("stb_word", mem_data, 32'hDEADBE55);

        // Stall then flush on a store: frozen outputs, no write.
        op(32'h20, 32'h11111111, 5'd2, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0); tick();
        op(32'h10, 32'h0, 5'd9, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1); tick();
        op(32'h20, 32'h22222222, 5'd7, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_md", mem_data, 32'hDEADBE55);
            chk("stall_alu", ALU_data, 32'h10);
            chk("stall_wb", {27'h0, wb_reg}, 32'd9);
        end
        flush = 1'b1;
        tick();
        chk_all_zero("flush");
        stall = 1'b0; flush = 1'b0;
        op(32'h20, 32'h0, 5'd1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1); tick();
        chk("no_write", mem_data, 32'h11111111);

        // Stall 3 cycles then release: single commit.
        op(32'h20, 32'h33333333, 5'd7, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall2_alu", ALU_data, 32'h20);
            chk("stall2_wb", {27'h0, wb_reg}, 32'd1);
        end
        stall = 1'b0;
        tick();
        chk("rel_wb", {27'h0, wb_reg}, 32'd7);
        chk("rel_rw", {31'h0, RegWrite}, 32'h1);
        op(32'h20, 32'h0, 5'd1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1); tick();
        chk("rel_ld", mem_data, 32'h33333333);

        // Half store into the low half.
        op(32'h22, 32'hFFFFABCD, 5'd0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0); tick();
        op(32'h20, 32'h0, 5'd1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1); tick();
        chk("sth_word", mem_data, 32'h3333ABCD);

        // Mid-stream reset, including a store that must be aborted.
        op(32'h10, 32'h44444444, 5'd4, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1);
        reset = 1'b0;
        tick();
        chk_all_zero("midreset");
        reset = 1'b1;
        op(32'h10, 32'h0, 5'd1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1); tick();
        chk("post_rst10", mem_data, 32'hDEADBE55);
        op(32'h20, 32'h0, 5'd1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1); tick();
        chk("post_rst20", mem_data, 32'h3333ABCD);

        // Misaligned word store.
        op(32'h12, 32'hA5A5A5A5, 5'd6, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0); tick();
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis_flag", {31'h0, misalign}, 32'h1);
        chk("mis_rw", {31'h0, RegWrite}, 32'h0);
`else
        chk("mis_flag", {31'h0, misalign}, 32'h0);
        chk("mis_rw", {31'h0, RegWrite}, 32'h1);
`endif
        op(32'h10, 32'h0, 5'd1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1); tick();
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis_mem", mem_data, 32'hDEADBE55);
`else
        chk("mis_mem", mem_data, 32'hA5A5A5A5);
`endif
        chk("mis_clr", {31'h0, misalign}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
